// File: rtl/dct_pkg.sv
// Shared DCT types: coefficient/vector typedefs and MSB-first bus pack/unpack helpers.
package dct_pkg;
    localparam int COEF_W = 9;
    localparam int N      = 8;
    localparam int IDX_W  = $clog2(N);
    localparam int BUS_W  = N * COEF_W;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef coef_t [N-1:0] vec_t;

    // Element k of a vector lives at bus slot k counted from the MSB end.
    function automatic vec_t unpack_vec(input logic [BUS_W-1:0] bus);
        vec_t v;
        for (int k = 0; k < N; k++) begin
            v[k] = bus[(N-k)*COEF_W-1 -: COEF_W];
        end
        return v;
    endfunction

    function automatic logic [BUS_W-1:0] pack_vec(input vec_t v);
        logic [BUS_W-1:0] bus;
        bus = '0;
        for (int k = 0; k < N; k++) begin
            bus[(N-k)*COEF_W-1 -: COEF_W] = v[k];
        end
        return bus;
    endfunction
endpackage

// File: rtl/dct_transpose_buffer_if.sv
// Row-in / column-out stream bundle for the transpose buffer.
interface dct_transpose_buffer_if;
    import dct_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] in_row;
    logic             out_valid;
    logic             out_ready;
    logic [BUS_W-1:0] out_col;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_col, out_idx, out_last
    );

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_col, out_idx, out_last
    );
endinterface

// File: rtl/dct_tp_bank.sv
// One N x N coefficient bank: row-wide write port, combinational column read port.
module dct_tp_bank
    import dct_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_row,
    input  vec_t             wr_vec,
    input  logic [IDX_W-1:0] rd_col,
    output vec_t             rd_vec
);
    coef_t mem [N][N];

    // Contents are deliberately not reset; the full flags gate any use of stale data.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < N; k++) begin
                mem[wr_row][k] <= wr_vec[k];
            end
        end
    end

    always_comb begin
        rd_vec = '0;
        for (int r = 0; r < N; r++) begin
            rd_vec[r] = mem[r][rd_col];
        end
    end
endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose between the row and column 1-D DCT stages.
module dct_transpose_buffer
    import dct_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    dct_transpose_buffer_if.slave bus
);
    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;
    logic [IDX_W-1:0] wr_row;
    logic [IDX_W-1:0] rd_col;
    logic             wr_fire;
    logic             rd_fire;
    vec_t             wr_vec;
    vec_t             rd_vec [2];

    assign wr_vec        = unpack_vec(bus.in_row);
    assign bus.in_ready  = !full[wr_bank];
    assign bus.out_valid = full[rd_bank];
    assign bus.out_idx   = rd_col;
    assign bus.out_last  = full[rd_bank] && (rd_col == IDX_W'(N-1));
    assign bus.out_col   = full[rd_bank] ? pack_vec(rd_vec[rd_bank]) : '0;
    assign wr_fire       = bus.in_valid && !full[wr_bank];
    assign rd_fire       = full[rd_bank] && bus.out_ready;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct_tp_bank u_bank (
            .clk    (clk),
            .we     (wr_fire && (wr_bank == 1'(b))),
            .wr_row (wr_row),
            .wr_vec (wr_vec),
            .rd_col (rd_col),
            .rd_vec (rd_vec[b])
        );
    end

    // Writer only touches a non-full bank and reader only a full one, so the
    // set and clear of full[] below never hit the same bit in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_col  <= '0;
        end else begin
            if (wr_fire) begin
                if (wr_row == IDX_W'(N-1)) begin
                    wr_row        <= '0;
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end else begin
                    wr_row <= wr_row + 1'b1;
                end
            end
            if (rd_fire) begin
                if (rd_col == IDX_W'(N-1)) begin
                    rd_col        <= '0;
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end else begin
                    rd_col <= rd_col + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Scoreboard bench: rows go in, a reference transpose predicts every column out.
module tb_dct_transpose_buffer;
    import dct_pkg::*;

    typedef struct {
        logic [BUS_W-1:0] col;
        int               idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dct_transpose_buffer_if bus ();

    dct_transpose_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t             exp_q [$];
    logic [BUS_W-1:0] part_q [$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fire_cnt = 0;
    int gap_cnt = 0;
    int last_fire = -10;
    int blk_cnt = 0;

    task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [COEF_W-1:0] gen_coef(input int mode, input int r, input int k);
        case (mode)
            0:       return COEF_W'(8*r + k);
            2:       return ((r + k) % 2 == 1) ? 9'h0FF : 9'h100;
            default: return COEF_W'($urandom);
        endcase
    endfunction

    function automatic bit roll(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    // Present rows 0..nrows-1 of one block; each row is held until accepted.
    task automatic send_rows(input int nrows, input int mode, input int p_in, input int p_out);
        logic [BUS_W-1:0] row;
        bit acc;
        int wait_cyc;
        for (int r = 0; r < nrows; r++) begin
            row = '0;
            for (int k = 0; k < N; k++) row[(N-k)*COEF_W-1 -: COEF_W] = gen_coef(mode, r, k);
            acc = 0;
            wait_cyc = 0;
            while (!acc) begin
                bus.in_valid  = roll(p_in);
                bus.in_row    = row;
                bus.out_ready = roll(p_out);
                @(negedge clk);
                acc = bus.in_valid && bus.in_ready;
                step();
                wait_cyc++;
                if (!acc && wait_cyc > 1000) begin
                    tests++;
                    fails++;
                    $display("FAIL row_accept_timeout: row %0d never accepted", r);
                    acc = 1;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int p_out);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            bus.out_ready = roll(p_out);
            @(negedge clk);
            step();
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d columns still expected", exp_q.size());
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("idle_out_valid", BUS_W'(bus.out_valid), BUS_W'(0));
        step();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", BUS_W'(bus.out_valid), BUS_W'(0));
        chk("rst_in_ready",  BUS_W'(bus.in_ready),  BUS_W'(1));
        chk("rst_out_idx",   BUS_W'(bus.out_idx),   BUS_W'(0));
        chk("rst_out_last",  BUS_W'(bus.out_last),  BUS_W'(0));
        chk("rst_out_col",   bus.out_col,           BUS_W'(0));
        step();
    endtask

    task automatic monitor_cycle();
        exp_t e;
        logic [BUS_W-1:0] col;
        cyc++;
        if (rst) begin
            exp_q.delete();
            part_q.delete();
        end else begin
            if (bus.in_valid && !bus.in_ready) blk_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_col: got idx %0d col %h with nothing expected", bus.out_idx, bus.out_col);
                end else begin
                    e = exp_q.pop_front();
                    chk("col_data", bus.out_col, e.col);
                    chk("col_idx", BUS_W'(bus.out_idx), BUS_W'(e.idx));
                    chk("col_last", BUS_W'(bus.out_last), BUS_W'(e.idx == N-1));
                end
                if (last_fire != cyc - 1) gap_cnt++;
                last_fire = cyc;
                fire_cnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                part_q.push_back(bus.in_row);
                if (part_q.size() == N) begin
                    // Column c gathers coefficient c of every row, row 0 in the MSB slot.
                    for (int c = 0; c < N; c++) begin
                        col = '0;
                        for (int r = 0; r < N; r++)
                            col[(N-r)*COEF_W-1 -: COEF_W] = part_q[r][(N-c)*COEF_W-1 -: COEF_W];
                        e.col = col;
                        e.idx = c;
                        exp_q.push_back(e);
                    end
                    part_q.delete();
                end
            end
        end
    endtask

    initial begin
        int f0, g0, b0;
        logic [BUS_W-1:0] held;

        fork
            forever begin
                @(negedge clk);
                monitor_cycle();
            end
        join_none

        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        pulse_reset();

        // Directed ramp block, then the one-cycle latency check.
        send_rows(N, 0, 100, 100);
        @(negedge clk);
        chk("latency_out_valid", BUS_W'(bus.out_valid), BUS_W'(1));
        chk("latency_out_idx",   BUS_W'(bus.out_idx),   BUS_W'(0));
        step();
        drain(100);

        // Streaming: four blocks back to back with full throughput.
        f0 = fire_cnt; g0 = gap_cnt; b0 = blk_cnt;
        for (int b = 0; b < 4; b++) send_rows(N, 1, 100, 100);
        drain(100);
        chk("stream_cols",      BUS_W'(fire_cnt - f0), BUS_W'(32));
        chk("stream_gaps",      BUS_W'(gap_cnt - g0),  BUS_W'(1));
        chk("stream_in_stalls", BUS_W'(blk_cnt - b0),  BUS_W'(0));

        // Backpressure: both banks fill, output must hold still.
        send_rows(N, 1, 100, 0);
        send_rows(N, 1, 100, 0);
        @(negedge clk);
        chk("bp_in_ready_low", BUS_W'(bus.in_ready), BUS_W'(0));
        held = bus.out_col;
        step();
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        chk("bp_col_stable", bus.out_col, held);
        chk("bp_idx_stable", BUS_W'(bus.out_idx), BUS_W'(0));
        step();
        for (int i = 0; i < N; i++) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            if (i == N-1) chk("bp_in_ready_before", BUS_W'(bus.in_ready), BUS_W'(0));
            step();
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_after", BUS_W'(bus.in_ready), BUS_W'(1));
        step();
        drain(100);

        // Signed extremes.
        send_rows(N, 2, 100, 100);
        drain(100);

        // Reset with a partial block (rows 0..5) in the write bank.
        send_rows(6, 1, 100, 0);
        pulse_reset();
        send_rows(N, 0, 100, 100);
        drain(100);

        // Reset mid-drain while column 3 is presented.
        send_rows(N, 1, 100, 0);
        for (int i = 0; i < 3; i++) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            step();
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("middrain_idx", BUS_W'(bus.out_idx), BUS_W'(3));
        step();
        pulse_reset();
        send_rows(N, 1, 100, 100);
        drain(100);

        // Random handshakes on both sides.
        for (int b = 0; b < 100; b++) send_rows(N, 1, 50, 50);
        drain(50);
        tests++;
        if (part_q.size() != 0) begin
            fails++;
            $display("FAIL leftover_rows: %0d rows unmatched", part_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
